// File: rtl/bit_deser16.sv
// Serial-to-parallel receiver: assembles a qualified bit stream into an index-ordered word after a start strobe.
// Optional even-parity check enabled by defining BIT_DESER16_PARITY_EN.
module bit_deser16 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_en,
    input  logic             in_bit,
    output logic [0:WIDTH-1] out,
    output logic             valid,
    output logic             busy
`ifdef BIT_DESER16_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

`ifdef BIT_DESER16_PARITY_EN
    localparam state_t ST_AFTER_SHIFT = ST_PARITY;
`else
    localparam state_t ST_AFTER_SHIFT = ST_DONE;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [0:WIDTH-1]   r_out;
    logic [0:WIDTH-1]   w_out_nxt;
    logic               r_valid;
    logic               r_busy;
    logic               w_last;
`ifdef BIT_DESER16_PARITY_EN
    logic               r_perr;
    logic               w_perr_nxt;
`endif

    assign w_last = (r_count == CNT_W'(WIDTH - 1));

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_out_nxt   = r_out;
`ifdef BIT_DESER16_PARITY_EN
        w_perr_nxt  = r_perr;
`endif
        case (r_state)
            ST_IDLE, ST_DONE: begin
                // DONE falls back to IDLE unless a new word starts immediately
                w_state_nxt = (r_state == ST_DONE) ? ST_IDLE : ST_IDLE;
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                    w_count_nxt = '0;
                    w_out_nxt   = '0;
`ifdef BIT_DESER16_PARITY_EN
                    w_perr_nxt  = 1'b0;
`endif
                end
            end
            ST_SHIFT: begin
                if (in_en) begin
                    w_out_nxt[r_count] = in_bit;
                    if (w_last) begin
                        w_state_nxt = ST_AFTER_SHIFT;
                    end else begin
                        w_count_nxt = r_count + CNT_W'(1);
                    end
                end
            end
`ifdef BIT_DESER16_PARITY_EN
            ST_PARITY: begin
                if (in_en) begin
                    w_perr_nxt  = (^r_out) ^ in_bit;
                    w_state_nxt = ST_DONE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; valid/busy track the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
`ifdef BIT_DESER16_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_out   <= w_out_nxt;
            r_valid <= (w_state_nxt == ST_DONE);
            r_busy  <= (w_state_nxt == ST_SHIFT);
`ifdef BIT_DESER16_PARITY_EN
            r_perr  <= w_perr_nxt;
`endif
        end
    end

    assign out   = r_out;
    assign valid = r_valid;
    assign busy  = r_busy;
`ifdef BIT_DESER16_PARITY_EN
    assign parity_err = r_perr;
`endif

endmodule
